// File: rtl/seq_101_tx.sv
// Serial frame transmitter: a 1,0,1 sync header, then DATA_W payload bits (MSB first),
// then GAP_LEN idle zeros. Out, Busy and Done are all driven straight from flops.
module seq_101_tx #(
    parameter int DATA_W  = 8,
    parameter int GAP_LEN = 2
) (
    input  logic              Clock,
    input  logic              Clr,
    input  logic              Load,
    input  logic [DATA_W-1:0] Data_In,
    output logic              Out,
    output logic              Busy,
    output logic              Done
);
    localparam int DCW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

    state_t            state, state_d;
    logic [DATA_W-1:0] sr, sr_d;
    logic [1:0]        hcnt, hcnt_d;
    logic [DCW-1:0]    dcnt, dcnt_d;
    logic [3:0]        gcnt, gcnt_d;
    logic              out_d, busy_d, done_d;

    always_ff @(posedge Clock or posedge Clr) begin
        if (Clr) begin
            state <= IDLE;
            sr    <= '0;
            hcnt  <= '0;
            dcnt  <= '0;
            gcnt  <= '0;
            Out   <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_d;
            sr    <= sr_d;
            hcnt  <= hcnt_d;
            dcnt  <= dcnt_d;
            gcnt  <= gcnt_d;
            Out   <= out_d;
            Busy  <= busy_d;
            Done  <= done_d;
        end
    end

    // Counters hold the index of the bit being driven this cycle, and the outputs are
    // computed for the next state, so that Out and Busy come straight from flops.
    always_comb begin
        state_d = state;
        sr_d    = sr;
        hcnt_d  = hcnt;
        dcnt_d  = dcnt;
        gcnt_d  = gcnt;
        out_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (Load) begin
                    sr_d    = Data_In;
                    hcnt_d  = 2'd0;
                    state_d = SYNC;
                    out_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SYNC: begin
                busy_d = 1'b1;
                if (hcnt == 2'd2) begin
                    state_d = DATA;
                    out_d   = sr[DATA_W-1];
                    sr_d    = sr << 1;
                    dcnt_d  = DCW'(1);
                end else begin
                    hcnt_d = hcnt + 2'd1;
                    // Header bit index 1 is 0 and index 2 is 1.
                    out_d  = (hcnt == 2'd1);
                end
            end
            DATA: begin
                if (dcnt == DCW'(DATA_W)) begin
                    if (GAP_LEN == 0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = GAP;
                        gcnt_d  = 4'd1;
                        busy_d  = 1'b1;
                    end
                end else begin
                    out_d  = sr[DATA_W-1];
                    sr_d   = sr << 1;
                    dcnt_d = dcnt + DCW'(1);
                    busy_d = 1'b1;
                end
            end
            GAP: begin
                if (gcnt == 4'(GAP_LEN)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    gcnt_d = gcnt + 4'd1;
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_seq_101_tx.sv
// Directed bench for seq_101_tx: default build (8-bit payload, 2-bit gap) and the
// DATA_W=1, GAP_LEN=0 corner build, sharing one clock and one Clr.
module tb_seq_101_tx;
    logic       Clock = 1'b0;
    logic       Clr   = 1'b1;
    logic       Load0 = 1'b0;
    logic [7:0] Data0 = 8'h00;
    logic       Out0, Busy0, Done0;
    logic       Load1 = 1'b0;
    logic       Data1 = 1'b0;
    logic       Out1, Busy1, Done1;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clock = ~Clock;

    seq_101_tx #(.DATA_W(8), .GAP_LEN(2)) u0 (
        .Clock(Clock), .Clr(Clr), .Load(Load0), .Data_In(Data0),
        .Out(Out0), .Busy(Busy0), .Done(Done0)
    );

    seq_101_tx #(.DATA_W(1), .GAP_LEN(0)) u1 (
        .Clock(Clock), .Clr(Clr), .Load(Load1), .Data_In(Data1),
        .Out(Out1), .Busy(Busy1), .Done(Done1)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the 13 frame cycles and the Done cycle of u0. The caller has already
    // issued the accepting edge. hold keeps Load high; inj_cyc (nonzero) raises
    // Load with inj_data during that frame cycle.
    task automatic run_frame(input string tag, input logic [12:0] exp, input int inj_cyc,
                             input logic [7:0] inj_data, input bit hold);
        for (int c = 1; c <= 13; c++) begin
            chk($sformatf("%s out c%0d", tag, c), Out0, exp[13-c]);
            chk($sformatf("%s busy c%0d", tag, c), Busy0, 1'b1);
            chk($sformatf("%s done c%0d", tag, c), Done0, 1'b0);
            if (c == inj_cyc) begin
                Load0 = 1'b1;
                Data0 = inj_data;
            end else if (!hold) begin
                Load0 = 1'b0;
            end
            tick();
        end
        chk({tag, " idle out"}, Out0, 1'b0);
        chk({tag, " idle busy"}, Busy0, 1'b0);
        chk({tag, " idle done"}, Done0, 1'b1);
    endtask

    initial begin
        // Reset held for two edges with Load high: nothing may start.
        Load0 = 1'b1;
        Data0 = 8'hA5;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst out", Out0, 1'b0);
            chk("rst busy", Busy0, 1'b0);
            chk("rst done", Done0, 1'b0);
            chk("rst busy1", Busy1, 1'b0);
            tick();
        end
        chk("rst out end", Out0, 1'b0);
        chk("rst busy end", Busy0, 1'b0);
        Clr = 1'b0;

        // Single A5 frame, accepted at the first edge after Clr falls.
        tick();
        run_frame("a5", 13'b101_10100101_00, 0, 8'h00, 1'b0);
        tick();
        chk("a5 done clears", Done0, 1'b0);
        chk("a5 stays idle", Busy0, 1'b0);

        // FF frame with a 3C load attempt in frame cycle 5, which must be ignored.
        Load0 = 1'b1;
        Data0 = 8'hFF;
        tick();
        run_frame("ff", 13'b101_11111111_00, 5, 8'h3C, 1'b0);
        tick();
        chk("ff no 2nd frame busy", Busy0, 1'b0);
        chk("ff no 2nd frame out", Out0, 1'b0);
        chk("ff done clears", Done0, 1'b0);

        // Clr between edges during DATA cycle 4 (frame cycle 7).
        Load0 = 1'b1;
        Data0 = 8'hFF;
        tick();
        Load0 = 1'b0;
        for (int i = 1; i < 7; i++) tick();
        chk("abort pre out", Out0, 1'b1);
        chk("abort pre busy", Busy0, 1'b1);
        #3;
        Clr = 1'b1;
        #1;
        chk("abort async out", Out0, 1'b0);
        chk("abort async busy", Busy0, 1'b0);
        chk("abort async done", Done0, 1'b0);
        tick();
        Clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort no done", Done0, 1'b0);
            chk("abort idle busy", Busy0, 1'b0);
        end
        Load0 = 1'b1;
        Data0 = 8'h01;
        tick();
        run_frame("01", 13'b101_00000001_00, 0, 8'h00, 1'b0);
        tick();

        // Back-to-back frames with Load held high throughout.
        Load0 = 1'b1;
        Data0 = 8'h00;
        tick();
        run_frame("b2b 00", 13'b101_00000000_00, 0, 8'h00, 1'b1);
        Data0 = 8'hFF;
        tick();
        run_frame("b2b ff", 13'b101_11111111_00, 0, 8'h00, 1'b1);
        Data0 = 8'h81;
        tick();
        run_frame("b2b 81", 13'b101_10000001_00, 0, 8'h00, 1'b0);
        tick();
        chk("b2b end busy", Busy0, 1'b0);
        chk("b2b end done", Done0, 1'b0);

        // Corner build: DATA_W=1, GAP_LEN=0, payload 1.
        Load1 = 1'b1;
        Data1 = 1'b1;
        tick();
        Load1 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("w1 out c%0d", c), Out1, (c == 2) ? 1'b0 : 1'b1);
            chk($sformatf("w1 busy c%0d", c), Busy1, 1'b1);
            chk($sformatf("w1 done c%0d", c), Done1, 1'b0);
            tick();
        end
        chk("w1 idle out", Out1, 1'b0);
        chk("w1 idle busy", Busy1, 1'b0);
        chk("w1 idle done", Done1, 1'b1);
        tick();
        chk("w1 done clears", Done1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
